// File: rtl/sirv_spigpioport_gen_if.sv
// rtl/sirv_spigpioport_gen_if.sv - SPI controller side bundle for the SPI-to-GPIO pin adapter
interface sirv_spigpioport_gen_if #(
  parameter int CS_NUM = 4,
  parameter int DQ_NUM = 4
);
  logic              sck;
  logic [DQ_NUM-1:0] dq_o;
  logic [DQ_NUM-1:0] dq_oe;
  logic [DQ_NUM-1:0] dq_i;
  logic [CS_NUM-1:0] cs;

  // SPI controller drives the pins' requested values and reads back lane data
  modport master (output sck, output dq_o, output dq_oe, output cs, input dq_i);
  // Pin adapter consumes the requests and returns synchronised lane data
  modport slave  (input sck, input dq_o, input dq_oe, input cs, output dq_i);
endinterface

// File: rtl/sirv_spigpioport_gen.sv
// rtl/sirv_spigpioport_gen.sv - parametrised SPI-to-GPIO IOF pin adapter (optional SIRV_SPIGPIO_LOOPBACK_EN)
module sirv_spigpioport_gen #(
  parameter int CS_NUM      = 4,
  parameter int DQ_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         port_en,
  input  logic [CS_NUM-1:0]            cs_idle,
  input  logic                         sck_idle,
`ifdef SIRV_SPIGPIO_LOOPBACK_EN
  input  logic                         loopback,
`endif
  sirv_spigpioport_gen_if.slave        io_spi,
  output logic                         io_pins_sck_o_oval,
  output logic                         io_pins_sck_o_oe,
  output logic                         io_pins_sck_o_ie,
  output logic                         io_pins_sck_o_pue,
  output logic                         io_pins_sck_o_ds,
  input  logic [DQ_NUM-1:0]            io_pins_dq_i_ival,
  output logic [DQ_NUM-1:0]            io_pins_dq_o_oval,
  output logic [DQ_NUM-1:0]            io_pins_dq_o_oe,
  output logic [DQ_NUM-1:0]            io_pins_dq_o_ie,
  output logic [DQ_NUM-1:0]            io_pins_dq_o_pue,
  output logic [DQ_NUM-1:0]            io_pins_dq_o_ds,
  output logic [CS_NUM-1:0]            io_pins_cs_o_oval,
  output logic [CS_NUM-1:0]            io_pins_cs_o_oe,
  output logic [CS_NUM-1:0]            io_pins_cs_o_ie,
  output logic [CS_NUM-1:0]            io_pins_cs_o_pue,
  output logic [CS_NUM-1:0]            io_pins_cs_o_ds,
  output logic                         port_active,
  output logic [1:0]                   port_state
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int          CW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  localparam logic [CW-1:0] TC = CW'(TURN_CYC);

  logic [1:0]        state, state_nxt;
  logic              pass;
  logic              lb;
  logic [CW-1:0]     ta_cnt [DQ_NUM];
  logic [DQ_NUM-1:0] lane_ready;
  logic [DQ_NUM-1:0] sync_q [SYNC_STAGES];
  logic [DQ_NUM-1:0] sync_in;

  logic              sck_oval_d, sck_oe_d;
  logic [CS_NUM-1:0] cs_oval_d, cs_oe_d, cs_pue_d;
  logic [DQ_NUM-1:0] dq_oval_d, dq_oe_d, dq_ie_d;

`ifdef SIRV_SPIGPIO_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  // ON and DRAIN both hand the pads straight to the controller
  assign pass        = state[1];
  assign port_active = pass;
  assign port_state  = state;

  // Constant pad controls: no drive-strength boost, sck never pulled, dq always pulled up
  assign io_pins_sck_o_ie  = 1'b0;
  assign io_pins_sck_o_pue = 1'b0;
  assign io_pins_sck_o_ds  = 1'b0;
  assign io_pins_dq_o_pue  = {DQ_NUM{1'b1}};
  assign io_pins_dq_o_ds   = {DQ_NUM{1'b0}};
  assign io_pins_cs_o_ie   = {CS_NUM{1'b0}};
  assign io_pins_cs_o_ds   = {CS_NUM{1'b0}};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= state_nxt;
  end

  // FSM next state: ownership only changes hands while every CS sits at its idle level
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   if (port_en) state_nxt = ST_ARM;
      ST_ARM:   if (!port_en) state_nxt = ST_OFF;
                else if (io_spi.cs == cs_idle) state_nxt = ST_ON;
      ST_ON:    if (!port_en) state_nxt = ST_DRAIN;
      ST_DRAIN: if (port_en) state_nxt = ST_ON;
                else if (io_spi.cs == cs_idle) state_nxt = ST_OFF;
      default:  state_nxt = ST_OFF;
    endcase
  end

  // A lane may drive once its request has been held for TURN_CYC cycles
  always_comb begin
    lane_ready = '0;
    for (int l = 0; l < DQ_NUM; l++) lane_ready[l] = (ta_cnt[l] == TC);
  end

  // Turnaround counters: saturate while requested, clear on release or when not passing through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < DQ_NUM; l++) ta_cnt[l] <= '0;
    end else begin
      for (int l = 0; l < DQ_NUM; l++) begin
        if (!pass || !io_spi.dq_oe[l]) ta_cnt[l] <= '0;
        else if (!lane_ready[l])       ta_cnt[l] <= ta_cnt[l] + CW'(1);
      end
    end
  end

  // FSM outputs: next value of every registered pad control
  always_comb begin
    sck_oval_d = 1'b0;
    sck_oe_d   = 1'b0;
    cs_oval_d  = {CS_NUM{1'b1}};
    cs_oe_d    = '0;
    cs_pue_d   = {CS_NUM{1'b1}};
    dq_oval_d  = '0;
    dq_oe_d    = '0;
    dq_ie_d    = '0;
    case (state)
      ST_ARM: begin
        sck_oval_d = sck_idle;
        sck_oe_d   = 1'b1;
        cs_oval_d  = cs_idle;
        cs_oe_d    = {CS_NUM{1'b1}};
      end
      ST_ON, ST_DRAIN: begin
        sck_oval_d = io_spi.sck;
        sck_oe_d   = 1'b1;
        cs_oval_d  = io_spi.cs;
        cs_oe_d    = {CS_NUM{1'b1}};
        cs_pue_d   = '0;
        dq_oval_d  = io_spi.dq_o;
        if (!lb) begin
          dq_oe_d = io_spi.dq_oe & lane_ready;
          dq_ie_d = ~(io_spi.dq_oe & lane_ready);
        end
      end
      default: ;
    endcase
  end

  // Pad output flops keep the pins glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_pins_sck_o_oval <= 1'b0;
      io_pins_sck_o_oe   <= 1'b0;
      io_pins_cs_o_oval  <= {CS_NUM{1'b1}};
      io_pins_cs_o_oe    <= '0;
      io_pins_cs_o_pue   <= {CS_NUM{1'b1}};
      io_pins_dq_o_oval  <= '0;
      io_pins_dq_o_oe    <= '0;
      io_pins_dq_o_ie    <= '0;
    end else begin
      io_pins_sck_o_oval <= sck_oval_d;
      io_pins_sck_o_oe   <= sck_oe_d;
      io_pins_cs_o_oval  <= cs_oval_d;
      io_pins_cs_o_oe    <= cs_oe_d;
      io_pins_cs_o_pue   <= cs_pue_d;
      io_pins_dq_o_oval  <= dq_oval_d;
      io_pins_dq_o_oe    <= dq_oe_d;
      io_pins_dq_o_ie    <= dq_ie_d;
    end
  end

  assign sync_in = lb ? io_spi.dq_o : io_pins_dq_i_ival;

  // Input synchroniser chain, active in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sync_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign io_spi.dq_i = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_sirv_spigpioport_gen.sv
// tb/tb_sirv_spigpioport_gen.sv - scoreboard bench for sirv_spigpioport_gen
module tb_sirv_spigpioport_gen;

  localparam int CS = 4;
  localparam int DQ = 4;
  localparam int SS = 2;
  localparam int TC = 1;

  typedef struct {
    int       tcyc;
    logic     sck_oval, sck_oe, act;
    logic [3:0] cs_oval, cs_oe, cs_pue, dq_oval, dq_oe, dq_ie, dq_i;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic port_en, sck_idle;
  logic [CS-1:0] cs_idle;
  logic [DQ-1:0] pins_ival;
  logic sck_oval, sck_oe, sck_ie, sck_pue, sck_ds;
  logic [DQ-1:0] dq_oval, dq_oe, dq_ie, dq_pue, dq_ds;
  logic [CS-1:0] cs_oval, cs_oe, cs_ie, cs_pue, cs_ds;
  logic port_active;
  logic [1:0] port_state;
  logic lb;

  sirv_spigpioport_gen_if #(.CS_NUM(CS), .DQ_NUM(DQ)) spi ();

`ifdef SIRV_SPIGPIO_LOOPBACK_EN
  logic loopback;
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  sirv_spigpioport_gen #(.CS_NUM(CS), .DQ_NUM(DQ), .SYNC_STAGES(SS), .TURN_CYC(TC)) dut (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .cs_idle(cs_idle), .sck_idle(sck_idle),
`ifdef SIRV_SPIGPIO_LOOPBACK_EN
    .loopback(loopback),
`endif
    .io_spi(spi),
    .io_pins_sck_o_oval(sck_oval), .io_pins_sck_o_oe(sck_oe), .io_pins_sck_o_ie(sck_ie),
    .io_pins_sck_o_pue(sck_pue), .io_pins_sck_o_ds(sck_ds),
    .io_pins_dq_i_ival(pins_ival),
    .io_pins_dq_o_oval(dq_oval), .io_pins_dq_o_oe(dq_oe), .io_pins_dq_o_ie(dq_ie),
    .io_pins_dq_o_pue(dq_pue), .io_pins_dq_o_ds(dq_ds),
    .io_pins_cs_o_oval(cs_oval), .io_pins_cs_o_oe(cs_oe), .io_pins_cs_o_ie(cs_ie),
    .io_pins_cs_o_pue(cs_pue), .io_pins_cs_o_ds(cs_ds),
    .port_active(port_active), .port_state(port_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];

  // reference model state
  int m_st;
  int run[DQ];
  logic [DQ-1:0] hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
  endtask

  task automatic model_reset();
    m_st = 0;
    for (int l = 0; l < DQ; l++) run[l] = 0;
    hist.delete();
    for (int s = 0; s < SS; s++) hist.push_back('0);
  endtask

  // Expected pad state after the coming edge, derived from the rules in plain terms
  task automatic model_step();
    exp_t e;
    bit on, grant;
    int nxt;
    on = (m_st == 2) || (m_st == 3);
    e.tcyc     = cyc + 1;
    e.sck_oe   = (m_st != 0);
    e.sck_oval = (m_st == 0) ? 1'b0 : (m_st == 1) ? sck_idle : spi.sck;
    e.cs_oe    = (m_st == 0) ? 4'h0 : 4'hF;
    e.cs_oval  = (m_st == 0) ? 4'hF : (m_st == 1) ? cs_idle : spi.cs;
    e.cs_pue   = on ? 4'h0 : 4'hF;
    e.dq_oval  = on ? spi.dq_o : 4'h0;
    for (int l = 0; l < DQ; l++) begin
      grant = on && spi.dq_oe[l] && (run[l] >= TC);
      e.dq_oe[l] = grant && !lb;
      e.dq_ie[l] = on && !lb && !grant;
      run[l] = (on && spi.dq_oe[l]) ? run[l] + 1 : 0;
    end
    hist.push_back(lb ? spi.dq_o : pins_ival);
    e.dq_i = hist[hist.size() - SS];
    void'(hist.pop_front());
    nxt = m_st;
    if (m_st == 0 && port_en) nxt = 1;
    else if (m_st == 1) nxt = !port_en ? 0 : (spi.cs == cs_idle) ? 2 : 1;
    else if (m_st == 2 && !port_en) nxt = 3;
    else if (m_st == 3) nxt = port_en ? 2 : (spi.cs == cs_idle) ? 0 : 3;
    e.st  = 2'(nxt);
    e.act = (nxt >= 2);
    m_st = nxt;
    sb.push_back(e);
  endtask

  task automatic drive(logic en, logic [3:0] cs, logic [3:0] oe, logic [3:0] dqo, logic [3:0] pins, logic sck);
    @(posedge clk);
    #1;
    port_en = en; spi.cs = cs; spi.dq_oe = oe; spi.dq_o = dqo; pins_ival = pins; spi.sck = sck;
    model_step();
  endtask

  task automatic reset_chk(string tag);
    chk({tag, "_cs_oval"}, 32'(cs_oval), 32'hF);
    chk({tag, "_oe"}, 32'({sck_oe, cs_oe, dq_oe}), 32'h0);
    chk({tag, "_ie"}, 32'({sck_ie, cs_ie, dq_ie}), 32'h0);
    chk({tag, "_pue"}, 32'({sck_pue, cs_pue, dq_pue}), 32'hFF);
    chk({tag, "_state"}, 32'({port_active, port_state}), 32'h0);
    chk({tag, "_dq_i"}, 32'(spi.dq_i), 32'h0);
    chk({tag, "_oval"}, 32'({sck_oval, dq_oval}), 32'h0);
  endtask

  // Monitor: every edge presents a pad vector; compare it against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].tcyc < cyc) begin
      chk("sb_stale", 32'(sb[0].tcyc), 32'(cyc));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].tcyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("sck", 32'({sck_oval, sck_oe}), 32'({e.sck_oval, e.sck_oe}));
      chk("cs_oval", 32'(cs_oval), 32'(e.cs_oval));
      chk("cs_oe_pue", 32'({cs_oe, cs_pue}), 32'({e.cs_oe, e.cs_pue}));
      chk("dq_oval", 32'(dq_oval), 32'(e.dq_oval));
      chk("dq_oe", 32'(dq_oe), 32'(e.dq_oe));
      chk("dq_ie", 32'(dq_ie), 32'(e.dq_ie));
      chk("dq_i", 32'(spi.dq_i), 32'(e.dq_i));
      chk("state", 32'({port_active, port_state}), 32'({e.act, e.st}));
      chk("const", 32'({sck_ie, sck_pue, sck_ds, cs_ie, cs_ds, dq_pue, dq_ds}), 32'h00F0);
    end
  end

  initial begin
    logic [3:0] oe_r;
    logic en_r;
    rst_n = 1'b0; port_en = 1'b0; cs_idle = 4'hF; sck_idle = 1'b0;
    pins_ival = '0; spi.sck = 1'b0; spi.cs = 4'hF; spi.dq_o = '0; spi.dq_oe = '0;
`ifdef SIRV_SPIGPIO_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_chk("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    model_step();

    // directed walk: idle, ARM held by active CS, ON, turnaround, DRAIN, OFF
    drive(0, 4'hF, 4'h0, 4'h0, 4'h8, 0);
    drive(0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    drive(1, 4'hE, 4'h0, 4'h0, 4'h8, 0);
    drive(1, 4'hE, 4'h0, 4'h0, 4'h8, 0);
    drive(1, 4'hE, 4'h0, 4'h0, 4'h0, 1);
    drive(1, 4'hF, 4'h0, 4'h0, 4'h8, 0);
    drive(1, 4'hE, 4'h1, 4'h5, 4'h0, 1);
    drive(1, 4'hE, 4'h1, 4'h5, 4'h8, 0);
    drive(1, 4'hE, 4'h1, 4'hA, 4'h8, 1);
    drive(1, 4'hE, 4'h0, 4'hA, 4'h0, 0);
    drive(0, 4'hE, 4'h3, 4'h3, 4'h8, 1);
    drive(0, 4'hE, 4'h3, 4'h3, 4'h0, 0);
    drive(0, 4'hF, 4'h3, 4'hC, 4'h8, 1);
    drive(0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
`ifdef SIRV_SPIGPIO_LOOPBACK_EN
    loopback = 1'b1;
    drive(0, 4'hF, 4'h0, 4'hA, 4'h5, 0);
    drive(0, 4'hF, 4'h0, 4'hA, 4'h5, 0);
    drive(0, 4'hF, 4'h0, 4'hA, 4'h5, 0);
`endif

    // randomized phase with sticky enables and held oe requests
    oe_r = '0; en_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) en_r = ~en_r;
      for (int l = 0; l < DQ; l++) if ($urandom_range(3) == 0) oe_r[l] = ~oe_r[l];
      if ($urandom_range(199) == 0) sck_idle = ~sck_idle;
      if ($urandom_range(299) == 0) cs_idle = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom);
`ifdef SIRV_SPIGPIO_LOOPBACK_EN
      if ($urandom_range(63) == 0) loopback = ~loopback;
`endif
      drive(en_r, ($urandom_range(2) == 0) ? 4'($urandom) : cs_idle, oe_r,
            4'($urandom), 4'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // asynchronous reset mid-activity returns everything to reset values at once
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_chk("rst2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sirv_spigpioport_gen.md
Name: sirv_spigpioport_gen

Overview:
Parametrised SPI-to-GPIO IOF pin adapter sitting between a sirv SPI master and the GPIO pad-control mux. Generalises the fixed 4-CS/4-DQ port to CS_NUM chip selects and DQ_NUM data lanes. Adds a registered (glitch-free) pad output stage, input synchronisers, per-lane bus-turnaround delay and an enable/handover FSM, so the pads are never driven mid-frame.

Parameters:
CS_NUM, 4, number of chip-select pins (1..8)
DQ_NUM, 4, number of data lanes (1, 2, 4 or 8)
SYNC_STAGES, 2, flops in each dq input synchroniser (>=1)
TURN_CYC, 1, dead cycles before a lane's pad oe may rise (0 = no delay)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
port_en  in  1  software enable for pin ownership
cs_idle  in  CS_NUM  inactive level per CS (1 = active-low CS)
sck_idle  in  1  SCK idle level (CPOL)
io_spi_sck  in  1  SPI serial clock from controller
io_spi_dq_o  in  DQ_NUM  lane output data
io_spi_dq_oe  in  DQ_NUM  lane output enable request
io_spi_dq_i  out  DQ_NUM  synchronised lane input data
io_spi_cs  in  CS_NUM  chip-select levels from controller
io_pins_sck_o_oval/_oe/_ie/_pue/_ds  out  1 each  SCK pad control
io_pins_dq_i_ival  in  DQ_NUM  dq pad input
io_pins_dq_o_oval/_oe/_ie/_pue/_ds  out  DQ_NUM each  dq pad control
io_pins_cs_o_oval/_oe/_ie/_pue/_ds  out  CS_NUM each  CS pad control
port_active  out  1  1 in ON or DRAIN
port_state  out  2  FSM state encoding

Behaviour:
- Reset (rst_n=0, async): state OFF; all pad outputs registered: oval=0 except cs oval=all ones; oe=0; ie=0; dq/cs pue=1, sck pue=0; ds=0; synchronisers, turnaround counters and io_spi_dq_i = 0.
- All pad outputs come from flops: 1-cycle latency from SPI-side inputs. ds always 0.
- FSM, encoding OFF=0, ARM=1, ON=2, DRAIN=3:
  - OFF: all pad oe=0, ie=0, dq/cs pue=1. port_en=1 -> ARM.
  - ARM: sck pad oe=1, oval=sck_idle; cs pads oe=1, oval=cs_idle; dq pads oe=0. Go to ON when io_spi_cs==cs_idle. port_en=0 -> OFF. port_en=0 takes priority over io_spi_cs==cs_idle in the same cycle.
  - ON: pass-through. sck oval=io_spi_sck, oe=1; cs oval=io_spi_cs, oe=1, pue=0; dq per lane as below. port_en=0 -> DRAIN.
  - DRAIN: pass-through as ON. io_spi_cs==cs_idle -> OFF; port_en=1 -> ON. If both hold in the same cycle, go to ON.
- DQ lane, ON/DRAIN only:
  - Pad oval=io_spi_dq_o.
  - oe falls in the same registered cycle io_spi_dq_oe falls.
  - oe rises only after io_spi_dq_oe has been 1 for TURN_CYC consecutive cycles. A per-lane counter saturates at TURN_CYC and clears whenever the request is 0.
  - ie = ~pad oe (registered together with oe); pue=1.
- Outside ON/DRAIN, turnaround counters are held at 0.
- io_spi_dq_i = io_pins_dq_i_ival delayed through SYNC_STAGES flops, in every state.
- Reset asserted mid-frame: immediate return to the reset values; no ordering guarantee on the pads.

Optional Feature:
SIRV_SPIGPIO_LOOPBACK_EN: adds input port loopback (1 bit).
- With the macro, loopback=1: dq pad oe forced 0 and ie forced 0; the synchroniser input takes io_spi_dq_o in place of io_pins_dq_i_ival. Same SYNC_STAGES latency, FSM unchanged.
- Without the macro: port absent, pad input always used.

Test Plan:
- Reset: rst_n=0 -> cs oval=4'hF, all oe=0, dq pue=1, port_state=0; release -> unchanged while port_en=0.
- port_en=1 with io_spi_cs=4'hE, cs_idle=4'hF -> ARM held, cs oval=4'hF; io_spi_cs=4'hF -> ON next cycle, port_active=1.
- ON, TURN_CYC=1: io_spi_dq_oe[0] 0->1 at cycle t -> pad oe[0]=1 at t+2, ie[0]=0; oe request 1->0 -> pad oe=0 at next edge.
- ON, port_en=0 with io_spi_cs=4'hE -> DRAIN, pass-through continues; io_spi_cs=4'hF -> OFF, all oe=0 next cycle.
- SYNC_STAGES=2: io_pins_dq_i_ival[3] toggles -> io_spi_dq_i[3] follows exactly 2 clocks later, in any state.
- SIRV_SPIGPIO_LOOPBACK_EN, loopback=1, io_spi_dq_o=4'hA -> io_spi_dq_i=4'hA after 2 clocks, dq pad oe=0.
